// File: rtl/four_bit_ctl_pkg.sv
// Shared types and constants for the four-bit counter run controller.
package four_bit_ctl_pkg;

  localparam int CNT_W_DEFAULT = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_HALT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_BLOWUP = 2'b01;
  localparam logic [1:0] ERR_STALL  = 2'b10;

endpackage

// File: rtl/run_stall_watchdog.sv
// Flags a counter that stops moving while enabled: pulses stall on the
// STALL_LIMIT-th consecutive cycle whose value equals the previous cycle's.
module run_stall_watchdog #(
  parameter int W           = 4,
  parameter int STALL_LIMIT = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         enable,
  input  logic [W-1:0] value,
  output logic         stall
);

  localparam logic [7:0] LIMIT_M1 = 8'(STALL_LIMIT - 1);

  logic [W-1:0] prev_q;
  logic         primed_q;
  logic [7:0]   cnt_q;
  logic         same;

  // The first enabled cycle has no valid previous value to compare against.
  assign same  = enable && primed_q && (value == prev_q);
  assign stall = same && (cnt_q == LIMIT_M1);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      prev_q   <= '0;
      primed_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      prev_q   <= value;
      primed_q <= enable;
      if (same) begin
        cnt_q <= cnt_q + 8'd1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/four_bit_run_controller.sv
// Initiator for the lab four-bit counter: clear, run to an exact target,
// halt and report, with blow_up and stall supervision.
module four_bit_run_controller
  import four_bit_ctl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int STALL_LIMIT = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             cmd_valid,
  input  logic [CNT_W-1:0] cmd_target,
  output logic             cmd_ready,
  input  logic             abort,
  input  logic             err_clr,
  input  logic [CNT_W-1:0] Counter_Out,
  input  logic             blow_up,
  output logic             start,
  output logic             stop,
  output logic             cnt_clear,
  output logic             done,
  output logic [CNT_W-1:0] result,
  output logic             aborted,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [2:0]       fsm_state
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] result_q;
  logic             aborted_q, aborted_next;
  logic [1:0]       err_code_q, err_code_next;
  logic             capture;
  logic             stall;

  run_stall_watchdog #(
    .W           (CNT_W),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_watchdog (
    .Clock  (Clock),
    .Reset  (Reset),
    .enable (state == S_RUN),
    .value  (Counter_Out),
    .stall  (stall)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      target_q   <= '0;
      result_q   <= '0;
      aborted_q  <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state      <= state_next;
      aborted_q  <= aborted_next;
      err_code_q <= err_code_next;
      if (capture) begin
        target_q <= cmd_target;
      end
      // The counter is stopped in HALT, so this value is what DONE reports.
      if (state == S_HALT && state_next == S_DONE) begin
        result_q <= Counter_Out;
      end
    end
  end

  // Priority in RUN: blow_up, stall, abort, then the target match. The match
  // uses target-1 because the counter takes one more increment on the exit edge.
  always_comb begin
    state_next    = state;
    aborted_next  = aborted_q;
    err_code_next = err_code_q;
    capture       = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_next   = S_CLEAR;
          aborted_next = 1'b0;
          capture      = 1'b1;
        end
      end
      S_CLEAR: begin
        if (blow_up) begin
          state_next    = S_ERROR;
          err_code_next = ERR_BLOWUP;
        end else if (target_q == '0) begin
          state_next = S_HALT;
        end else begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (blow_up) begin
          state_next    = S_ERROR;
          err_code_next = ERR_BLOWUP;
        end else if (stall) begin
          state_next    = S_ERROR;
          err_code_next = ERR_STALL;
        end else if (abort) begin
          state_next   = S_HALT;
          aborted_next = 1'b1;
        end else if (Counter_Out == target_q - ONE) begin
          state_next = S_HALT;
        end
      end
      S_HALT: begin
        if (blow_up) begin
          state_next    = S_ERROR;
          err_code_next = ERR_BLOWUP;
        end else begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      S_ERROR: begin
        if (err_clr) begin
          state_next    = S_IDLE;
          err_code_next = ERR_NONE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Every control output is a decode of the state register, so reset forces
  // stop high asynchronously.
  assign start     = (state == S_RUN);
  assign stop      = (state != S_RUN);
  assign cnt_clear = (state == S_CLEAR);
  assign cmd_ready = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign err       = (state == S_ERROR);
  assign result    = result_q;
  assign aborted   = aborted_q;
  assign err_code  = err_code_q;
  assign fsm_state = state;

endmodule

// File: doc/four_bit_run_controller.md
Name: four_bit_run_controller

Overview:
- Initiator side of the start/stop/Counter_Out/blow_up interface of the lab four-bit counter.
- Accepts a run command carrying a target count, then sequences the counter: clear, start, stop exactly at the target, and report.
- Monitors blow_up and counter stalls, and flags errors.
- Sits between the front-panel/CPU command logic and one four-bit counter instance.

Parameters:
- CNT_W, 4, counter width; target and result width.
- STALL_LIMIT, 8, consecutive RUN cycles with unchanged Counter_Out before a stall error (range 2..255).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  run command present.
- cmd_target  in  CNT_W  target final count.
- cmd_ready  out  1  controller can accept a command.
- abort  in  1  early stop request, honoured in RUN only.
- err_clr  in  1  clears a sticky error.
- Counter_Out  in  CNT_W  counter value.
- blow_up  in  1  counter overflow flag.
- start  out  1  counter run request.
- stop  out  1  counter halt request.
- cnt_clear  out  1  one-cycle synchronous clear to the counter.
- done  out  1  one-cycle completion pulse.
- result  out  CNT_W  counter value captured at completion.
- aborted  out  1  qualifies done: the run was cut short.
- err  out  1  sticky error.
- err_code  out  2  00 none, 01 blow_up, 10 stall.

Behaviour:
- Counter contract:
  - Increments by 1 at every Clock edge where start=1 and stop=0.
  - Goes to 0 at the edge where cnt_clear=1.
- Reset (Reset=0, asynchronous):
  - State IDLE.
  - start=0, stop=1, cnt_clear=0, done=0, aborted=0, err=0, err_code=00, result=0.
  - target_q=0, stall counter=0.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.
- States: IDLE, CLEAR, RUN, HALT, DONE, ERROR.
- IDLE:
  - cmd_ready=1, start=0, stop=1.
  - On cmd_valid at edge T: capture target_q, go to CLEAR.
- CLEAR (cycle T+1): cnt_clear=1, start=0, stop=1.
  - If target_q=0, go to HALT.
  - Otherwise go to RUN.
- RUN: start=1, stop=0.
  - Halt compare uses target_q-1, because the counter takes one more increment on the exit edge. The final count therefore equals target_q exactly.
  - If Counter_Out = target_q-1, go to HALT.
  - Example: target 5 gives first RUN cycle at T+2, HALT at T+7, Counter_Out=5 in HALT.
- HALT: start=0, stop=1.
  - Next cycle goes to DONE.
- DONE (one cycle):
  - done=1, result=Counter_Out, aborted as latched.
  - Then go to IDLE; cmd_ready returns the cycle after done.
- abort in RUN:
  - Go to HALT and latch aborted=1.
  - result is whatever Counter_Out holds in DONE.
  - abort in any other state is ignored.
  - aborted clears on the next command acceptance.
- blow_up=1 in CLEAR, RUN or HALT:
  - Go to ERROR with err_code=01.
  - blow_up has priority over abort and over the target match in the same cycle.
- Stall detection:
  - Within RUN, a counter increments when Counter_Out equals its previous-cycle value and resets when the value differs.
  - When the counter reaches STALL_LIMIT, go to ERROR with err_code=10.
  - The counter is zeroed on RUN entry.
- ERROR:
  - start=0, stop=1, err=1, cmd_ready=0.
  - err_clr=1 clears err and err_code to 00 and returns to IDLE.
  - cmd_valid is ignored while in ERROR.
- blow_up in IDLE or DONE is ignored.
- cmd_valid in the same cycle as err_clr in ERROR is ignored; only the clear takes effect.
- Reset asserted mid-run: immediate return to reset values, with stop=1 asynchronously. The counter keeps its value; the next command clears it.
- target_q is not updated while busy; cmd_valid during a run is not accepted.

Decomposition:
- Package four_bit_ctl_pkg:
  - State enumeration (IDLE..ERROR).
  - err_code constants ERR_NONE, ERR_BLOWUP, ERR_STALL.
  - CNT_W default.
- Sub-module run_stall_watchdog:
  - Inputs: Clock, Reset, enable (state==RUN), value.
  - Output: stall pulse.
  - Parameter: STALL_LIMIT.
- The FSM and output registers stay in the top module.

Test Plan:
- Reset held low 3 cycles, then released: start=0, stop=1, cmd_ready=1, err=0, result=0.
- cmd_target=5 with a behavioural counter model:
  - cnt_clear pulses at T+1.
  - start high for exactly 5 cycles.
  - done at T+8 with result=5, aborted=0.
- cmd_target=0: start is never asserted; done pulses with result=0.
- cmd_target=15: exactly 15 increments, result=15, blow_up never asserted, err=0.
- cmd_target=9, abort at RUN cycle 3: done with aborted=1 and result=3.
- Fault injection:
  - Force blow_up=1 in RUN: ERROR, err_code=01, stop=1; err_clr returns to IDLE.
  - Freeze the model counter for 8 cycles: err_code=10.
  - Drop Reset mid-RUN: stop goes to 1 immediately.
